// File: rtl/lcd_bus_decoder.sv
// rtl/lcd_bus_decoder.sv - 8080-style write-bus responder decoding window commands and RAMWR pixels
//
// Purpose: captures bytes on the rising edge of wr (synchronous to clk), decodes
// CASET/PASET/RAMWR/SWRESET/SLPOUT/DISPON/DISPOFF, and emits one RGB565 pixel
// per completed RAMWR byte pair at auto-incremented window coordinates.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   wr         bus write strobe, byte captured on its low-to-high transition
//   dcx        0 = command byte, 1 = parameter/data byte
//   D          bus data
//   pix_valid  one-cycle pulse per pixel written
//   pix_x      pixel column (held until next pixel)
//   pix_y      pixel row (held until next pixel)
//   pix_color  RGB565 value {high byte, low byte}
//   disp_on    display enabled
//   sleep_out  set by SLPOUT
//   cmd_err    one-cycle pulse on an unrecognised command byte
//   pix_count  (LCD_RX_STATS_EN) saturating pixel count since reset/SWRESET
//   frame_done (LCD_RX_STATS_EN) pulse with the pixel written at (EC, EP)
//
// Optional feature macro: LCD_RX_STATS_EN

module lcd_bus_decoder #(
  parameter int COL_W   = 9,
  parameter int ROW_W   = 9,
  parameter int COL_MAX = 319,
  parameter int ROW_MAX = 239
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             dcx,
  input  logic [7:0]       D,
  output logic             pix_valid,
  output logic [COL_W-1:0] pix_x,
  output logic [ROW_W-1:0] pix_y,
  output logic [15:0]      pix_color,
  output logic             disp_on,
  output logic             sleep_out,
  output logic             cmd_err
`ifdef LCD_RX_STATS_EN
  ,
  output logic [15:0]      pix_count,
  output logic             frame_done
`endif
);

  localparam logic [COL_W-1:0] EC_RST = COL_W'(COL_MAX);
  localparam logic [ROW_W-1:0] EP_RST = ROW_W'(ROW_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAM_HI,
    S_RAM_LO
  } state_t;

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      parm_q, parm_d;
  logic [COL_W-1:0] sc_q, sc_d, ec_q, ec_d, col_q, col_d;
  logic [ROW_W-1:0] sp_q, sp_d, ep_q, ep_d, row_q, row_d;
  logic [7:0]       hi_q, hi_d;
  logic             pix_valid_q, pix_valid_d;
  logic [COL_W-1:0] pix_x_q, pix_x_d;
  logic [ROW_W-1:0] pix_y_q, pix_y_d;
  logic [15:0]      pix_color_q, pix_color_d;
  logic             disp_on_q, disp_on_d;
  logic             sleep_out_q, sleep_out_d;
  logic             cmd_err_q, cmd_err_d;
`ifdef LCD_RX_STATS_EN
  logic [15:0]      pix_count_q, pix_count_d;
  logic             frame_done_q, frame_done_d;
`endif

  logic             wr_rise;
  logic [15:0]      start16, end16;
  logic [COL_W-1:0] c_start, c_end;
  logic [ROW_W-1:0] r_start, r_end;

  always_comb begin
    wr_rise     = wr & ~wr_q;
    wr_d        = wr;
    state_d     = state_q;
    idx_d       = idx_q;
    parm_d      = parm_q;
    sc_d        = sc_q;
    ec_d        = ec_q;
    sp_d        = sp_q;
    ep_d        = ep_q;
    col_d       = col_q;
    row_d       = row_q;
    hi_d        = hi_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    disp_on_d   = disp_on_q;
    sleep_out_d = sleep_out_q;
    cmd_err_d   = 1'b0;
`ifdef LCD_RX_STATS_EN
    pix_count_d  = pix_count_q;
    frame_done_d = 1'b0;
`endif

    // Buffered bytes are {start_hi, start_lo, end_hi}; end_lo is the live byte.
    start16 = parm_q[23:8];
    end16   = {parm_q[7:0], D};
    c_start = COL_W'(start16);
    c_end   = COL_W'(end16);
    r_start = ROW_W'(start16);
    r_end   = ROW_W'(end16);

    if (wr_rise) begin
      if (!dcx) begin
        // Any command abandons a partial parameter or pixel sequence.
        state_d = S_IDLE;
        idx_d   = 2'd0;
        parm_d  = '0;
        unique case (D)
          8'h2A: state_d = S_CASET;
          8'h2B: state_d = S_PASET;
          8'h2C: begin
            state_d = S_RAM_HI;
            col_d   = sc_q;
            row_d   = sp_q;
          end
          8'h01: begin
            sc_d        = '0;
            ec_d        = EC_RST;
            sp_d        = '0;
            ep_d        = EP_RST;
            col_d       = '0;
            row_d       = '0;
            disp_on_d   = 1'b0;
            sleep_out_d = 1'b0;
`ifdef LCD_RX_STATS_EN
            pix_count_d = '0;
`endif
          end
          8'h11: sleep_out_d = 1'b1;
          8'h29: disp_on_d   = 1'b1;
          8'h28: disp_on_d   = 1'b0;
          default: cmd_err_d = 1'b1;
        endcase
      end else begin
        unique case (state_q)
          S_CASET, S_PASET: begin
            parm_d = {parm_q[15:0], D};
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = S_IDLE;
              idx_d   = 2'd0;
              if (state_q == S_CASET) begin
                sc_d = c_start;
                ec_d = (c_end < c_start) ? c_start : c_end;
              end else begin
                sp_d = r_start;
                ep_d = (r_end < r_start) ? r_start : r_end;
              end
            end
          end
          S_RAM_HI: begin
            hi_d    = D;
            state_d = S_RAM_LO;
          end
          S_RAM_LO: begin
            state_d     = S_RAM_HI;
            pix_valid_d = 1'b1;
            pix_x_d     = col_q;
            pix_y_d     = row_q;
            pix_color_d = {hi_q, D};
`ifdef LCD_RX_STATS_EN
            if (pix_count_q != 16'hFFFF) pix_count_d = pix_count_q + 16'd1;
            frame_done_d = (col_q == ec_q) && (row_q == ep_q);
`endif
            // Raster advance within the window, wrapping to (SC, SP) after the last row.
            if (col_q == ec_q) begin
              col_d = sc_q;
              row_d = (row_q == ep_q) ? sp_q : row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b1;
      idx_q       <= 2'd0;
      parm_q      <= '0;
      sc_q        <= '0;
      ec_q        <= EC_RST;
      sp_q        <= '0;
      ep_q        <= EP_RST;
      col_q       <= '0;
      row_q       <= '0;
      hi_q        <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      disp_on_q   <= 1'b0;
      sleep_out_q <= 1'b0;
      cmd_err_q   <= 1'b0;
`ifdef LCD_RX_STATS_EN
      pix_count_q  <= '0;
      frame_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      parm_q      <= parm_d;
      sc_q        <= sc_d;
      ec_q        <= ec_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hi_q        <= hi_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      disp_on_q   <= disp_on_d;
      sleep_out_q <= sleep_out_d;
      cmd_err_q   <= cmd_err_d;
`ifdef LCD_RX_STATS_EN
      pix_count_q  <= pix_count_d;
      frame_done_q <= frame_done_d;
`endif
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign disp_on   = disp_on_q;
  assign sleep_out = sleep_out_q;
  assign cmd_err   = cmd_err_q;
`ifdef LCD_RX_STATS_EN
  assign pix_count  = pix_count_q;
  assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb/tb_lcd_bus_decoder.sv - scoreboard bench for lcd_bus_decoder with randomized bus traffic
module tb_lcd_bus_decoder;

  localparam int COL_W = 9;
  localparam int ROW_W = 9;
  localparam int CMASK = (1 << COL_W) - 1;
  localparam int RMASK = (1 << ROW_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr  = 1'b1;
  logic             dcx = 1'b0;
  logic [7:0]       D   = 8'h00;
  logic             pix_valid;
  logic [COL_W-1:0] pix_x;
  logic [ROW_W-1:0] pix_y;
  logic [15:0]      pix_color;
  logic             disp_on;
  logic             sleep_out;
  logic             cmd_err;
`ifdef LCD_RX_STATS_EN
  logic [15:0]      pix_count;
  logic             frame_done;
`endif

  lcd_bus_decoder #(.COL_W(COL_W), .ROW_W(ROW_W), .COL_MAX(319), .ROW_MAX(239)) dut (
    .clk(clk), .rst(rst), .wr(wr), .dcx(dcx), .D(D),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .disp_on(disp_on), .sleep_out(sleep_out), .cmd_err(cmd_err)
`ifdef LCD_RX_STATS_EN
    , .pix_count(pix_count), .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int color;
    int cyc;
    int cnt;
    bit fd;
  } pix_t;

  pix_t exp_q[$];
  int   err_q[$];

  // Reference model: window bounds as integers, position derived from pixel ordinal.
  int   m_mode;              // 0 idle, 1 caset, 2 paset, 3 ramwr
  int   m_params[$];
  int   m_sc, m_ec, m_sp, m_ep;
  int   r_sc, r_ec, r_sp, r_ep;
  int   m_n;
  bit   m_have_hi;
  int   m_hi;
  bit   m_disp, m_sleep;
  int   m_cnt;

  task automatic model_reset();
    m_mode = 0; m_params.delete();
    m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
    r_sc = 0; r_ec = 319; r_sp = 0; r_ep = 239;
    m_n = 0; m_have_hi = 0; m_hi = 0;
    m_disp = 0; m_sleep = 0; m_cnt = 0;
  endtask

  task automatic model_byte(input bit c, input int d, input int stamp);
    pix_t e;
    int s, en, w, h;
    if (!c) begin
      m_params.delete();
      m_have_hi = 0;
      m_mode = 0;
      case (d)
        'h2A: m_mode = 1;
        'h2B: m_mode = 2;
        'h2C: begin
          m_mode = 3; m_n = 0;
          r_sc = m_sc; r_ec = m_ec; r_sp = m_sp; r_ep = m_ep;
        end
        'h01: begin
          m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
          m_disp = 0; m_sleep = 0; m_cnt = 0;
        end
        'h11: m_sleep = 1;
        'h29: m_disp = 1;
        'h28: m_disp = 0;
        default: err_q.push_back(stamp);
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_params.push_back(d);
      if (m_params.size() == 4) begin
        s  = m_params[0] * 256 + m_params[1];
        en = m_params[2] * 256 + m_params[3];
        if (m_mode == 1) begin
          s = s & CMASK; en = en & CMASK;
          if (en < s) en = s;
          m_sc = s; m_ec = en;
        end else begin
          s = s & RMASK; en = en & RMASK;
          if (en < s) en = s;
          m_sp = s; m_ep = en;
        end
        m_params.delete();
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_have_hi) begin
        m_hi = d; m_have_hi = 1;
      end else begin
        w = r_ec - r_sc + 1;
        h = r_ep - r_sp + 1;
        e.x = r_sc + (m_n % w);
        e.y = r_sp + ((m_n / w) % h);
        e.color = m_hi * 256 + d;
        e.cyc = stamp;
        if (m_cnt < 65535) m_cnt++;
        e.cnt = m_cnt;
        e.fd = (e.x == r_ec) && (e.y == r_ep);
        exp_q.push_back(e);
        m_n++;
        m_have_hi = 0;
      end
    end
  endtask

  // One bus write; the model is updated once the DUT has registered the byte,
  // and the stamp is the cycle in which the resulting pulse must be visible.
  task automatic bus_write(input bit c, input logic [7:0] d);
    repeat ($urandom_range(0, 1)) @(posedge clk);
    @(posedge clk); #1;
    wr = 1'b0; dcx = c; D = d;
    @(posedge clk); #1;
    wr = 1'b1;
    @(posedge clk); #1;
    model_byte(c, int'(d), cyc);
  endtask

  task automatic send_window(input logic [7:0] cmd, input int s, input int e);
    bus_write(1'b0, cmd);
    bus_write(1'b1, s[15:8]);
    bus_write(1'b1, s[7:0]);
    bus_write(1'b1, e[15:8]);
    bus_write(1'b1, e[7:0]);
  endtask

  task automatic send_pix(input int color);
    bus_write(1'b1, color[15:8]);
    bus_write(1'b1, color[7:0]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; wr = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compares every presented pixel / error pulse against the queues.
  always @(negedge clk) begin
    pix_t e;
    if (!rst) begin
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pix_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
          check("pix_color", pix_color, e.color);
          check("pix_latency_cycle", cyc, e.cyc);
`ifdef LCD_RX_STATS_EN
          check("pix_count", pix_count, e.cnt);
          check("frame_done", frame_done, e.fd);
`endif
        end
      end
`ifdef LCD_RX_STATS_EN
      else if (frame_done) check("frame_done_without_pixel", 1, 0);
`endif
      if (cmd_err) begin
        if (err_q.size() == 0) check("unexpected_cmd_err", 1, 0);
        else check("cmd_err_cycle", cyc, err_q.pop_front());
      end
      check("disp_on", disp_on, m_disp);
      check("sleep_out", sleep_out, m_sleep);
    end
  end

  initial begin
    int s, e, k, cmd;
    model_reset();
    do_reset();

    // Idle bus after reset: everything at zero.
    repeat (20) @(posedge clk);
    #1;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_color", pix_color, 0);
`ifdef LCD_RX_STATS_EN
    check("rst_pix_count", pix_count, 0);
`endif

    // 2x2 window with a wrap on the fifth pixel.
    send_window(8'h2A, 'h000A, 'h000B);
    send_window(8'h2B, 'h0005, 'h0006);
    bus_write(1'b0, 8'h2C);
    send_pix('hF800); send_pix('h07E0); send_pix('h001F); send_pix('hFFFF);
    send_pix('h1234);

    // Abort a half pixel with DISPON; the following data byte lands in IDLE.
    bus_write(1'b0, 8'h2C);
    bus_write(1'b1, 8'hAB);
    bus_write(1'b0, 8'h29);
    bus_write(1'b1, 8'hCD);
    check("disp_on_after_abort", disp_on, 1);

    // Reversed column bounds collapse to a single column.
    send_window(8'h2A, 'h0014, 'h000A);
    send_window(8'h2B, 'h0000, 'h00EF);
    bus_write(1'b0, 8'h2C);
    send_pix('h0001); send_pix('h0002); send_pix('h0003);

    // Unknown command, then SWRESET after SLPOUT/DISPON.
    bus_write(1'b0, 8'h55);
    bus_write(1'b0, 8'h11);
    bus_write(1'b0, 8'h29);
    check("sleep_out_set", sleep_out, 1);
    bus_write(1'b0, 8'h01);
    check("swreset_disp_on", disp_on, 0);
    check("swreset_sleep_out", sleep_out, 0);
    // Full default row: 321 pixels cross from (319,0) to (0,1).
    bus_write(1'b0, 8'h2C);
    for (int i = 0; i < 321; i++) send_pix(i * 7);

    // Reset landing on a low-byte edge: no pixel may appear.
    bus_write(1'b0, 8'h2C);
    bus_write(1'b1, 8'h12);
    @(posedge clk); #1;
    wr = 1'b0; dcx = 1'b1; D = 8'h34;
    @(posedge clk); #1;
    wr = 1'b1; rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midseq_reset_no_pix", pix_valid, 0);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      s = $urandom_range(0, 20) + (($urandom_range(0, 3) == 0) ? 300 : 0);
      e = ($urandom_range(0, 5) == 0) ? s - 1 : s + $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) begin s = $urandom_range(0, 65535); e = $urandom_range(0, 65535); end
      send_window(8'h2A, s, e);
      s = $urandom_range(0, 20);
      e = s + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) e = s - 1;
      send_window(8'h2B, s, e);
      if ($urandom_range(0, 3) == 0) bus_write(1'b1, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        do cmd = $urandom_range(0, 255);
        while (cmd inside {'h01, 'h11, 'h28, 'h29, 'h2A, 'h2B, 'h2C});
        bus_write(1'b0, 8'(cmd));
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: bus_write(1'b0, 8'h11);
          1: bus_write(1'b0, 8'h29);
          default: bus_write(1'b0, 8'h28);
        endcase
      end
      // Partially written CASET that gets aborted.
      if ($urandom_range(0, 5) == 0) begin
        bus_write(1'b0, 8'h2A);
        bus_write(1'b1, 8'h00);
        bus_write(1'b1, 8'h05);
      end
      bus_write(1'b0, 8'h2C);
      k = $urandom_range(0, 14);
      for (int i = 0; i < k; i++) send_pix($urandom_range(0, 65535));
      if ($urandom_range(0, 4) == 0) begin
        bus_write(1'b1, 8'($urandom_range(0, 255)));
        bus_write(1'b0, ($urandom_range(0, 1) == 0) ? 8'h29 : 8'h2A);
      end
      if ($urandom_range(0, 9) == 0) bus_write(1'b0, 8'h01);
    end

    repeat (5) @(posedge clk);
    #1;
    check("pix_queue_drained", exp_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
